// File: rtl/board_ram_arbiter_pkg.sv
// Shared constants and types for the board RAM arbiter slice.
// No logic; latency and backpressure are defined by the modules that import it.
package board_ram_arbiter_pkg;

    localparam int RAM_ADDR_W  = 8;
    localparam int RAM_DATA_W  = 6;
    localparam int BOARD_COLS  = 10;
    localparam int BOARD_ROWS  = 24;
    localparam int COLOR_EMPTY = 0;

    localparam int REQ_COLLIDE = 0;
    localparam int REQ_ROTATE  = 1;
    localparam int REQ_WRITE   = 2;
    localparam int REQ_CLEAR   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_ram_arbiter_if.sv
// Requester-side bundle of the board RAM arbiter: request/address/data in, grant/read data out.
// Latency: none (wires); backpressure: requesters hold req until they own the grant.
interface board_ram_arbiter_if
    import board_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_wren;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        rdata_valid;
    logic                      busy;

    modport master (
        output req, req_addr, req_wdata, req_wren,
        input  grant, rdata, rdata_valid, busy
    );

    modport slave (
        input  req, req_addr, req_wdata, req_wren,
        output grant, rdata, rdata_valid, busy
    );
endinterface

// File: rtl/board_ram_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping; one-hot result.
// Latency: combinational; backpressure: none.
module board_ram_arbiter_rr_pick
    import board_ram_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = ptr_w(N)
)(
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);
    logic [PW:0] slot;

    always_comb begin
        win  = '0;
        any  = 1'b0;
        slot = '0;
        for (int k = 0; k < N; k++) begin
            slot = {1'b0, ptr} + (PW+1)'(k);
            if (slot >= (PW+1)'(N)) begin
                slot = slot - (PW+1)'(N);
            end
            if (!any && req[slot[PW-1:0]]) begin
                win[slot[PW-1:0]] = 1'b1;
                any               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Round-robin, grant-locked owner of the single-port board RAM; reads return 1 cycle after issue.
// Backpressure: requesters hold req until granted; owner change costs one bubble unless preempted by MAX_HOLD.
module board_ram_arbiter
    import board_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = RAM_ADDR_W,
    parameter int DATA_W   = RAM_DATA_W,
    parameter int MAX_HOLD = 0
)(
    input logic                clk,
    input logic                reset,
    board_ram_arbiter_if.slave bus
);
    localparam int IW        = ptr_w(NUM_REQ);
    localparam int HW        = $clog2(MAX_HOLD + 2);
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HW-1:0] HOLD_LAST_V = HW'(HOLD_LAST);
    localparam logic [HW-1:0] HOLD_MAX_V  = HW'(MAX_HOLD);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] rvld_q;

    logic [IW-1:0]      owner, owner_next, pick_ptr;
    logic [NUM_REQ-1:0] others, pick_req, pick_win, rd_issue;
    logic               owner_req, hold_hit, pick_any;

    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_data, ram_q;
    logic               ram_wren;
    logic [DATA_W-1:0]  mem [DEPTH];

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner = IW'(i);
            end
        end
    end

    assign owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign owner_req  = |(bus.req & grant_q);
    assign others     = bus.req & ~grant_q;
    // Preempt on the owner's MAX_HOLD-th cycle so it gets exactly MAX_HOLD accesses.
    assign hold_hit   = (MAX_HOLD > 0) && (hold_q >= HOLD_LAST_V) && (|others);

    assign pick_req = (state_q == ST_OWNED) ? others     : bus.req;
    assign pick_ptr = (state_q == ST_OWNED) ? owner_next : ptr_q;

    board_ram_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .win (pick_win),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_win;
                    hold_d  = '0;
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!owner_req || hold_hit) begin
                    grant_d = pick_win;
                    ptr_d   = owner_next;
                    hold_d  = '0;
                    state_d = pick_any ? ST_OWNED : ST_IDLE;
                end else if (hold_q < HOLD_MAX_V) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            rvld_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            rvld_q  <= rd_issue;
        end
    end

    // Write is gated by reset so a burst caught by reset leaves the RAM untouched.
    always_comb begin
        ram_addr = '0;
        ram_data = DATA_W'(COLOR_EMPTY);
        ram_wren = 1'b0;
        rd_issue = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                ram_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
                ram_data    = bus.req_wdata[i*DATA_W +: DATA_W];
                ram_wren    = bus.req_wren[i] & bus.req[i] & ~reset;
                rd_issue[i] = bus.req[i] & ~bus.req_wren[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    assign bus.grant       = grant_q;
    assign bus.rdata       = ram_q;
    assign bus.rdata_valid = rvld_q;
    assign bus.busy        = |grant_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: per-cycle grant traces and a read-data scoreboard checked against a RAM model.
module tb_board_ram_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    board_ram_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    board_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_g   = 0;

    logic [DW-1:0] model [256];
    logic [AW-1:0] addr_c [N];
    logic [DW-1:0] wd_c   [N];
    logic          wr_c   [N];
    logic [N-1:0]  req_v;
    bit            pend   [N];
    int            beats  [N];
    int            nbeats [N];
    int            nburst [N];
    int            start  [N];

    logic [N-1:0]  exp_g [$];
    int            sb_t  [$];
    logic [N-1:0]  sb_v  [$];
    logic [DW-1:0] sb_d  [$];

    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = addr_c[i];
            bus.req_wdata[i*DW +: DW] = wd_c[i];
            bus.req_wren[i]           = wr_c[i];
        end
        bus.req = req_v;
    endtask

    task automatic cfg(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit w, input int nb, input int nbu, input int st);
        addr_c[i] = a;
        wd_c[i]   = d;
        wr_c[i]   = w;
        nbeats[i] = nb;
        nburst[i] = nbu;
        start[i]  = st;
        pend[i]   = 1'b0;
    endtask

    task automatic push_g(input logic [N-1:0] g, input int n);
        repeat (n) exp_g.push_back(g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_v = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_rvld", bus.rdata_valid, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
    endtask

    // Requesters hold req for nbeats granted cycles, drop for one cycle, then relaunch if bursts remain.
    task automatic run(input int budget);
        int           cyc;
        bit           done;
        bit           idle;
        logic [N-1:0] g;
        logic [N-1:0] e;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            #1;
            g = bus.grant;
            if (exp_g.size() > 0) begin
                e = exp_g.pop_front();
                chk("grant", g, e);
                chk("busy", bus.busy, |e);
            end
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if (g[i]) begin
                        if (beats[i] > 0) begin
                            beats[i]--;
                            if (wr_c[i]) begin
                                model[addr_c[i]] = wd_c[i];
                            end else begin
                                sb_t.push_back(cyc_g + 1);
                                sb_v.push_back(N'(1) << i);
                                sb_d.push_back(model[addr_c[i]]);
                            end
                        end else begin
                            pend[i]  = 1'b0;
                            req_v[i] = 1'b0;
                        end
                    end
                end else if (nburst[i] > 0 && cyc >= start[i]) begin
                    pend[i]  = 1'b1;
                    beats[i] = nbeats[i];
                    nburst[i]--;
                    req_v[i] = 1'b1;
                end
            end
            drive();
            #1;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    if (pend[i]) begin
                        chk("ram_addr", dut.ram_addr, addr_c[i]);
                        chk("ram_wren", dut.ram_wren, wr_c[i]);
                    end else begin
                        chk("bubble_wren", dut.ram_wren, 0);
                    end
                end
            end
            idle = (g == '0);
            for (int i = 0; i < N; i++) begin
                if (pend[i] || nburst[i] > 0) idle = 1'b0;
            end
            done = idle;
            cyc++;
        end
        chk("run_done", done, 1);
        chk("trace_left", exp_g.size(), 0);
        exp_g.delete();
    endtask

    always @(negedge clk) begin
        if (sb_t.size() > 0 && sb_t[0] == cyc_g) begin
            void'(sb_t.pop_front());
            chk("rdata_valid", bus.rdata_valid, sb_v.pop_front());
            chk("rdata", bus.rdata, sb_d.pop_front());
        end else if (bus.rdata_valid != '0) begin
            chk("rvld_spurious", bus.rdata_valid, 0);
        end
    end

    initial begin
        req_v = '0;
        for (int i = 0; i < N; i++) cfg(i, '0, '0, 1'b0, 0, 0, 0);
        drive();
        do_reset();

        // Preload: addr 12 <- 5, addr 50 <- 2 through requester 2
        cfg(2, 8'd12, 6'd5, 1'b1, 1, 1, 0);
        push_g(4'b0000, 1); push_g(4'b0100, 2); push_g(4'b0000, 1);
        run(50);
        cfg(2, 8'd50, 6'd2, 1'b1, 1, 1, 0);
        push_g(4'b0000, 1); push_g(4'b0100, 2); push_g(4'b0000, 1);
        run(50);

        // Single read by requester 0
        do_reset();
        cfg(0, 8'd12, 6'd0, 1'b0, 1, 1, 0);
        push_g(4'b0000, 1); push_g(4'b0001, 2); push_g(4'b0000, 1);
        run(50);

        // Requesters 1 and 2 together: 1 first, one bubble, then 2
        do_reset();
        cfg(1, 8'd12, 6'd0, 1'b0, 2, 1, 0);
        cfg(2, 8'd50, 6'd0, 1'b0, 2, 1, 0);
        push_g(4'b0000, 1); push_g(4'b0010, 3); push_g(4'b0100, 3); push_g(4'b0000, 1);
        run(50);

        // Requester 2 writes 3 to addr 40, requester 0 reads it back
        cfg(2, 8'd40, 6'd3, 1'b1, 1, 1, 0);
        cfg(0, 8'd40, 6'd0, 1'b0, 1, 1, 2);
        push_g(4'b0000, 1); push_g(4'b0100, 2); push_g(4'b0001, 2); push_g(4'b0000, 1);
        run(50);

        // Hold limit: requester 0 preempted after 4 cycles by requester 3
        cfg(0, 8'd12, 6'd0, 1'b0, 10, 1, 0);
        cfg(3, 8'd40, 6'd0, 1'b0, 2, 1, 2);
        push_g(4'b0000, 1); push_g(4'b0001, 4); push_g(4'b1000, 3);
        push_g(4'b0001, 7); push_g(4'b0000, 1);
        run(60);

        // Reset arriving in the first cycle of a write burst to addr 50
        cfg(2, 8'd50, 6'd7, 1'b1, 0, 0, 0);
        req_v = 4'b0100;
        drive();
        @(posedge clk);
        #1;
        chk("mid_grant", bus.grant, 4'b0100);
        chk("mid_wren_pre", dut.ram_wren, 1);
        reset = 1'b1;
        #1;
        chk("mid_wren_gated", dut.ram_wren, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_grant", bus.grant, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rvld", bus.rdata_valid, 0);
        reset = 1'b0;
        req_v = '0;
        drive();
        cfg(0, 8'd50, 6'd0, 1'b0, 1, 1, 0);
        push_g(4'b0000, 1); push_g(4'b0001, 2); push_g(4'b0000, 1);
        run(50);

        // All four requesters, 3 beats each, requester 0 twice
        do_reset();
        cfg(0, 8'd12, 6'd0, 1'b0, 3, 2, 0);
        cfg(1, 8'd60, 6'd9, 1'b1, 3, 1, 0);
        cfg(2, 8'd40, 6'd0, 1'b0, 3, 1, 0);
        cfg(3, 8'd61, 6'd4, 1'b1, 3, 1, 0);
        push_g(4'b0000, 1); push_g(4'b0001, 4); push_g(4'b0010, 4); push_g(4'b0100, 4);
        push_g(4'b1000, 4); push_g(4'b0001, 4); push_g(4'b0000, 1);
        run(100);

        // Read back the round-robin writes; pointer now at 1
        cfg(1, 8'd60, 6'd0, 1'b0, 1, 1, 0);
        cfg(3, 8'd61, 6'd0, 1'b0, 1, 1, 0);
        push_g(4'b0000, 1); push_g(4'b0010, 2); push_g(4'b1000, 2); push_g(4'b0000, 1);
        run(50);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb_t.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Shares the single-port board RAM (256 x 6 bit, registered read, 1-cycle latency) between the game modules: collision, rotation check, add-to-RAM, row clear, board draw and board clear.
- Removes the per-state address/data/wren muxing from the game controller.
- Round-robin arbitration with grant lock and optional anti-starvation hold limit.
- Instantiates and drives the RAM itself; requesters see grant plus a read-data-valid strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, RAM address width.
- DATA_W, 6, RAM data width (colour code).
- MAX_HOLD, 0, maximum consecutive grant cycles before forced re-arbitration when others are pending; 0 disables the limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request, held for the whole burst.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i is at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_wren  in  NUM_REQ  per-requester write enable.
- grant  out  NUM_REQ  one-hot current owner, registered.
- rdata  out  DATA_W  RAM q, shared by all requesters.
- rdata_valid  out  NUM_REQ  one-hot; bit i high on the cycle rdata holds the result of requester i's read.
- busy  out  1  high while any grant is active.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - grant = 0, rdata_valid = 0, busy = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Hold counter = 0.
  - RAM contents are not touched.
- States:
  - IDLE (no owner).
  - OWNED (grant one-hot).
- IDLE:
  - If any req is high, grant at the next edge goes to the first requester at or after the pointer (wrapping modulo NUM_REQ); go to OWNED.
  - Otherwise stay in IDLE.
- OWNED:
  - While req[owner] stays high (and the hold limit is not hit), grant holds (lock).
  - If req[owner] drops, that cycle performs no access. At the next edge the block re-arbitrates from owner+1 and sets pointer = owner+1.
  - Result: one bubble cycle between owners; grant goes 0 if nobody is pending, returning to IDLE.
- MAX_HOLD > 0:
  - The counter increments each OWNED cycle and resets on owner change.
  - When it reaches MAX_HOLD and another req is pending, grant moves to the next pending requester at the following edge, even if req[owner] is still high.
  - The preempted requester must keep req asserted and resume once re-granted; its address is its own concern.
- RAM drive (combinational from registered grant):
  - ram_addr = req_addr[owner], ram_data = req_wdata[owner].
  - ram_wren = req_wren[owner] AND req[owner] AND grant-active.
  - With no owner: addr = 0, data = 0, wren = 0.
- Read latency:
  - A cycle with grant[i], req[i] high and req_wren[i] low issues a read.
  - rdata_valid[i] pulses exactly 1 cycle later, even if grant has since moved.
  - Writes never raise rdata_valid.
- Simultaneous requests: strict round-robin from the pointer; no requester waits more than NUM_REQ-1 bursts.
- Reset mid-burst:
  - grant and rdata_valid clear at the reset edge.
  - Any pending write that cycle is suppressed (wren gated by not reset).
- busy = OR of grant.
- Out-of-range owner index cannot occur; grant is one-hot or zero.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, board dimensions (10 x 24), colour code for empty cell (0).
- Requester index constants: REQ_COLLIDE = 0, REQ_ROTATE = 1, REQ_WRITE = 2, REQ_CLEAR = 3.
- One sub-module, rr_pick: combinational round-robin picker (req vector, pointer -> one-hot winner, any-valid). Reused by future VGA arbitration.
- The RAM instance lives inside this block.

Test Plan:
- Reset then req=0001 with addr 8'd12, read -> grant=0001 one cycle later; ram_addr=12; rdata_valid=0001 the following cycle with preloaded value 6'd5.
- req=0110 asserted together after reset -> grant 0010 first; on req[1] drop, one bubble, then grant=0100; pointer now 2.
- Requester 2 writes 6'd3 to addr 40, releases; requester 0 then reads addr 40 -> rdata=3 with rdata_valid=0001; no rdata_valid during the write.
- MAX_HOLD=4: req[0] held indefinitely, req[3] raised -> grant moves to 1000 after 4 owned cycles; req[0] re-granted after req[3] drops.
- Reset asserted during a write burst (req[2], wren=1) -> grant=0 at that edge; RAM address unchanged by the suppressed write; busy=0.
- All four requesters held continuously with release after 3 cycles each -> grant order 0,1,2,3,0 with exactly one bubble between owners.
